// File: rtl/multichannel_wr_arbiter.sv
// multichannel_wr_arbiter: grants one of four write channels at a time to a
// single AXI write master. Channels that have not yet been served in the
// current round win first; ties are broken round-robin after the last grant.
// A grant is held until the master reports wr_done, or until the watchdog
// fires after TIMEOUT_CYC busy cycles (0 disables the watchdog).
module multichannel_wr_arbiter #(
  parameter int ADDR_WIDTH  = 30,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr0,
  input  logic [ADDR_WIDTH-1:0] wr_addr1,
  input  logic [ADDR_WIDTH-1:0] wr_addr2,
  input  logic [ADDR_WIDTH-1:0] wr_addr3,
  output logic [3:0]            wr_grant,
  input  logic                  wr_done,
  output logic                  axi_wr_start,
  output logic [ADDR_WIDTH-1:0] axi_wr_addr,
  output logic                  wr_timeout
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    S0   = 5'b00010,
    S1   = 5'b00100,
    S2   = 5'b01000,
    S3   = 5'b10000
  } state_t;

  // Counter only needs to reach TIMEOUT_CYC-1.
  localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
  localparam bit            WD_EN    = (TIMEOUT_CYC > 0);

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic [3:0]    record_q, record_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       legal;
  logic       in_s;
  logic [1:0] cur;
  logic       cur_req;
  logic       wd_fire;
  logic       release_burst;
  logic       decide;
  logic       pick_valid;
  logic [1:0] pick_ch;
  logic [1:0] scan_idx;
  logic [3:0] rec_n;

  // Decode the one-hot state into "granted channel" and drive the grant-side outputs.
  always_comb begin
    legal = 1'b1;
    in_s  = 1'b1;
    cur   = 2'd0;
    case (state_q)
      IDLE:    in_s = 1'b0;
      S0:      cur = 2'd0;
      S1:      cur = 2'd1;
      S2:      cur = 2'd2;
      S3:      cur = 2'd3;
      default: begin
        legal = 1'b0;
        in_s  = 1'b0;
      end
    endcase
    cur_req       = wr_req[cur];
    wr_grant      = in_s ? state_q[4:1] : 4'b0000;
    axi_wr_start  = in_s & cur_req & ~busy_q;
    // wr_done wins over a coincident watchdog expiry.
    wd_fire       = WD_EN & in_s & busy_q & (cnt_q == CNT_LAST) & ~wr_done;
    release_burst = in_s & busy_q & (wr_done | wd_fire);
    wr_timeout    = wd_fire;
    axi_wr_addr   = '0;
    if (in_s) begin
      case (cur)
        2'd0:    axi_wr_addr = wr_addr0;
        2'd1:    axi_wr_addr = wr_addr1;
        2'd2:    axi_wr_addr = wr_addr2;
        default: axi_wr_addr = wr_addr3;
      endcase
    end
  end

  // Two-pass round-robin scan starting after the last granted channel.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = 2'd0;
    scan_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!pick_valid && wr_req[scan_idx] && !record_q[scan_idx]) begin
        pick_valid = 1'b1;
        pick_ch    = scan_idx;
      end
    end
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!pick_valid && wr_req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_ch    = scan_idx;
      end
    end
  end

  // Next-state: busy tracking, watchdog count and grant decisions.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    record_d = record_q;
    last_d   = last_q;
    cnt_d    = '0;
    rec_n    = record_q | (4'b0001 << pick_ch);
    decide   = (state_q == IDLE) | release_burst | (in_s & ~busy_q & ~cur_req);
    if (!legal) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      if (release_burst) begin
        busy_d = 1'b0;
      end else if (axi_wr_start) begin
        busy_d = 1'b1;
      end
      if (busy_q && !release_burst) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (decide) begin
        if (pick_valid) begin
          last_d   = pick_ch;
          record_d = (&rec_n) ? 4'b0000 : rec_n;
          case (pick_ch)
            2'd0:    state_d = S0;
            2'd1:    state_d = S1;
            2'd2:    state_d = S2;
            default: state_d = S3;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // State registers; async reset gives channel 0 first priority (last=3).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      record_q <= 4'b0000;
      last_q   <= 2'd3;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      record_q <= record_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
